// File: rtl/msg_buffer.sv
// msg_buffer: double-banked message buffer, UART bytes in and scroller chars out; define MSG_UPCASE_EN to store a-z as A-Z
module msg_buffer #(
  parameter int         DEPTH    = 32,
  parameter logic [7:0] PAD_CHAR = 8'h20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  input  logic [7:0]               wr_data,
  output logic                     wr_ready,
  input  logic                     rd_req,
  output logic                     rd_valid,
  output logic [7:0]               rd_char,
  output logic [$clog2(DEPTH):0]   msg_len,
  output logic                     swap_pend
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  typedef enum logic {FILL, HOLD} wr_state_t;
  typedef enum logic {CHAR, EOL} rd_state_t;
  logic [7:0] mem [2][DEPTH];
  logic sel;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] shadow_len;
  wr_state_t wr_st;
  rd_state_t rd_st;
  logic [7:0] wbyte;
  logic acc, is_lf, is_cr, store, term, wrap, swap;
`ifdef MSG_UPCASE_EN
  assign wbyte = (wr_data >= 8'h61 && wr_data <= 8'h7A) ? wr_data - 8'h20 : wr_data;
`else
  assign wbyte = wr_data;
`endif
  assign acc   = wr_valid && wr_ready && wr_st == FILL;
  assign is_lf = wr_data == 8'h0A;
  assign is_cr = wr_data == 8'h0D;
  assign store = acc && !is_lf && !is_cr;
  assign term  = (acc && is_lf && wr_ptr != '0) || (store && wr_ptr == AW'(DEPTH - 1));
  assign wrap  = rd_req && (msg_len == '0 || rd_st == EOL);
  assign swap  = wrap && swap_pend;
  // shadow bank write; banks are never reset
  always_ff @(posedge clk)
    if (store) mem[~sel][wr_ptr] <= wbyte;
  // write FSM: fill the shadow bank until a newline or a full bank, then hold until the swap
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_st      <= FILL;
      wr_ready   <= 1'b0;
      wr_ptr     <= '0;
      shadow_len <= '0;
      swap_pend  <= 1'b0;
    end else if (swap) begin
      wr_st     <= FILL;
      wr_ready  <= 1'b1;
      wr_ptr    <= '0;
      swap_pend <= 1'b0;
    end else begin
      if (store) wr_ptr <= wr_ptr + AW'(1);
      if (term) begin
        wr_st      <= HOLD;
        wr_ready   <= 1'b0;
        swap_pend  <= 1'b1;
        shadow_len <= store ? LW'(DEPTH) : {1'b0, wr_ptr};
      end else wr_ready <= wr_st == FILL;
    end
  // read FSM: answer each request next cycle, newline after the last char, swap banks at the wrap
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_st    <= CHAR;
      rd_ptr   <= '0;
      rd_valid <= 1'b0;
      rd_char  <= PAD_CHAR;
      msg_len  <= '0;
      sel      <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      if (swap) begin
        sel     <= ~sel;
        msg_len <= shadow_len;
      end
      if (rd_req) begin
        if (msg_len == '0) rd_char <= PAD_CHAR;
        else if (rd_st == EOL) begin
          rd_char <= 8'h0A;
          rd_ptr  <= '0;
          rd_st   <= CHAR;
        end else begin
          rd_char <= mem[sel][rd_ptr];
          rd_ptr  <= rd_ptr + AW'(1);
          if ({1'b0, rd_ptr} == msg_len - LW'(1)) rd_st <= EOL;
        end
      end
    end
endmodule

// File: tb/tb_msg_buffer.sv
// tb_msg_buffer: scoreboard bench for msg_buffer at DEPTH=32
module tb_msg_buffer;
  logic clk = 0, rst_n = 1, wr_valid = 0, rd_req = 0;
  logic [7:0] wr_data = 0;
  logic wr_ready, rd_valid, swap_pend;
  logic [7:0] rd_char;
  logic [5:0] msg_len;
  logic prev_req = 0;
  logic [7:0] exp_q[$];
  logic [7:0] e;
  int checks = 0, failures = 0;

  msg_buffer dut (.clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
                  .rd_req(rd_req), .rd_valid(rd_valid), .rd_char(rd_char), .msg_len(msg_len), .swap_pend(swap_pend));

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) prev_req <= 1'b0;
    else prev_req <= rd_req;

  always @(negedge clk)
    if (rst_n) begin
      checks++;
      if (rd_valid !== prev_req) begin
        failures++;
        $display("FAIL rd_valid: got %b expected %b at %0t", rd_valid, prev_req, $time);
      end
      if (prev_req) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rd_char_unexpected: got %h with empty scoreboard at %0t", rd_char, $time);
        end else begin
          e = exp_q.pop_front();
          if (rd_char !== e) begin
            failures++;
            $display("FAIL rd_char: got %h expected %h at %0t", rd_char, e, $time);
          end
        end
      end
    end

  task automatic send(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    wr_valid = 1;
    wr_data  = b;
    while (!wr_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: wr_ready stayed %b, expected 1 for byte %h", wr_ready, b);
    end
    @(posedge clk);
    #1 wr_valid = 0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic issue_reads(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rd_req = 1;
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        rd_req = 0;
      end
    end
    @(negedge clk);
    rd_req = 0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    #1 rst_n = 0;
    #3;
    checks++;
    if ({wr_ready, rd_valid, rd_char, msg_len, swap_pend} !== {1'b0, 1'b0, 8'h20, 6'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_values: got rdy=%b val=%b char=%h len=%0d pend=%b expected 0 0 20 0 0",
               wr_ready, rd_valid, rd_char, msg_len, swap_pend);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    checks++;
    if (wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_before_clock: got %b expected 0", wr_ready);
    end
    @(negedge clk);
    checks++;
    if (wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_clock: got %b expected 1", wr_ready);
    end
  endtask

  task automatic test_empty_reads;
    push_str("   ");
    issue_reads(3, 0);
    checks++;
    if (msg_len !== 6'd0) begin
      failures++;
      $display("FAIL empty_len: got %0d expected 0", msg_len);
    end
  endtask

  task automatic test_hi;
    send_str("HI\n");
    @(negedge clk);
    checks++;
    if ({swap_pend, wr_ready} !== 2'b10) begin
      failures++;
      $display("FAIL hi_hold: got pend=%b rdy=%b expected 1 0", swap_pend, wr_ready);
    end
    push_str(" HI\n");
    issue_reads(4, 0);
    checks++;
    if ({msg_len, swap_pend, wr_ready, rd_char} !== {6'd2, 1'b0, 1'b1, 8'h0A}) begin
      failures++;
      $display("FAIL hi_after: got len=%0d pend=%b rdy=%b char=%h expected 2 0 1 0a",
               msg_len, swap_pend, wr_ready, rd_char);
    end
  endtask

  task automatic test_back_to_back;
    send_str("AB\n");
    push_str("HI\n");
    issue_reads(3, 0);
    push_str("AB\nXY\n");
    fork
      send_str("XY\n");
      begin
        issue_reads(2, 3);
        checks++;
        if ({swap_pend, msg_len} !== {1'b1, 6'd2}) begin
          failures++;
          $display("FAIL b2b_pending: got pend=%b len=%0d expected 1 2", swap_pend, msg_len);
        end
        issue_reads(1, 0);
        checks++;
        if ({swap_pend, wr_ready} !== 2'b01) begin
          failures++;
          $display("FAIL b2b_swapped: got pend=%b rdy=%b expected 0 1", swap_pend, wr_ready);
        end
        issue_reads(3, 0);
      end
    join
  endtask

  task automatic test_overflow;
    string s = "";
    for (int i = 0; i < 32; i++) s = {s, string'(8'h30 + 8'(i))};
    send_str(s);
    @(negedge clk);
    wr_valid = 1;
    wr_data  = "Z";
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({wr_ready, swap_pend, msg_len} !== {1'b0, 1'b1, 6'd2}) begin
        failures++;
        $display("FAIL full_hold: got rdy=%b pend=%b len=%0d expected 0 1 2", wr_ready, swap_pend, msg_len);
      end
      @(negedge clk);
    end
    wr_valid = 0;
    push_str("XY\n");
    issue_reads(3, 0);
    checks++;
    if ({msg_len, swap_pend} !== {6'd32, 1'b0}) begin
      failures++;
      $display("FAIL full_len: got len=%0d pend=%b expected 32 0", msg_len, swap_pend);
    end
    send_str("Z\n");
    push_str({s, "\n"});
    issue_reads(33, 0);
    checks++;
    if (msg_len !== 6'd1) begin
      failures++;
      $display("FAIL z_len: got %0d expected 1", msg_len);
    end
  endtask

  task automatic test_crlf;
    send_str("\r\n");
    @(negedge clk);
    checks++;
    if ({swap_pend, wr_ready} !== 2'b01) begin
      failures++;
      $display("FAIL crlf_ignored: got pend=%b rdy=%b expected 0 1", swap_pend, wr_ready);
    end
    send_str("a\n");
    push_str("Z\n");
`ifdef MSG_UPCASE_EN
    push_str("A\n");
`else
    push_str("a\n");
`endif
    issue_reads(4, 0);
    checks++;
    if (msg_len !== 6'd1) begin
      failures++;
      $display("FAIL a_len: got %0d expected 1", msg_len);
    end
  endtask

  task automatic test_async_reset;
    send_str("AB");
    @(negedge clk);
    wr_valid = 1;
    wr_data  = "C";
    #2 rst_n = 0;
    #1;
    checks++;
    if ({wr_ready, rd_valid, rd_char, msg_len, swap_pend} !== {1'b0, 1'b0, 8'h20, 6'd0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset: got rdy=%b val=%b char=%h len=%0d pend=%b expected 0 0 20 0 0",
               wr_ready, rd_valid, rd_char, msg_len, swap_pend);
    end
    wr_valid = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    push_str("   ");
    issue_reads(3, 0);
    send_str("C\n");
    push_str(" C\n");
    issue_reads(3, 0);
  endtask

  initial begin
    test_reset;
    test_empty_reads;
    test_hi;
    test_back_to_back;
    test_overflow;
    test_crlf;
    test_async_reset;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
